// File: rtl/nano_ctrl_hs.sv
// -----------------------------------------------------------------------------
// nano_ctrl_hs
// Handshaking control unit for the Nano processor datapath. A multi-state FSM
// runs fetch, decode and PC update. It drives the datapath strobes: ALU
// command, register write, write-data mux, branch/jump selects, PC load and
// output load. It also handles three handshakes: an instruction-memory
// request/ack, valid/ready for the INPUT instruction, and valid/ready for the
// OUTPUT instruction. A counter tracks retired instructions.
//
// Parameters
//   DATA_W     width of ResultULA; bit DATA_W-1 is the sign
//   CNT_W      width of the retired-instruction counter
//
// Ports
//   clk        clock, rising-edge active
//   rst        asynchronous reset, active low
//   OP         opcode; valid while imem_ack=1 and held until the next fetch
//   ResultULA  ALU result used by the conditional branches
//   imem_ack   instruction memory has OP ready
//   in_valid   external input word available
//   out_ready  external sink accepts the output word
//   imem_req   fetch request
//   in_ready   controller is waiting for an input word
//   out_valid  output register holds an unconsumed word
//   CmdULA     ALU command (TSTR1=0, ADD=1, AND=2, OR=3, SUB=4, NEG=5, NOT=6)
//   selDtWr    register write-data select (00 ALU, 01 immediate, 10 input)
//   SelRegWr   write-address select, 1 only for LRG
//   Wr         register-file write strobe
//   LdPC       PC load strobe
//   SelJMP     jump select
//   SelDesv    branch-taken select
//   LdOUTPUT   output-register load strobe
//   estado     current FSM state
//   instr_cnt  retired-instruction count, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module nano_ctrl_hs #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               OP,
    input  logic signed [DATA_W-1:0] ResultULA,
    input  logic                     imem_ack,
    input  logic                     in_valid,
    input  logic                     out_ready,
    output logic                     imem_req,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [2:0]               CmdULA,
    output logic [1:0]               selDtWr,
    output logic                     SelRegWr,
    output logic                     Wr,
    output logic                     LdPC,
    output logic                     SelJMP,
    output logic                     SelDesv,
    output logic                     LdOUTPUT,
    output logic [2:0]               estado,
    output logic [CNT_W-1:0]         instr_cnt
);

    typedef enum logic [2:0] {
        S_CLR   = 3'd0,
        S_FETCH = 3'd1,
        S_DEC   = 3'd2,
        S_NEXT  = 3'd3,
        S_WIN   = 3'd4,
        S_WOUT  = 3'd5
    } state_e;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_ADD    = 4'h1;
    localparam logic [3:0] OP_AND    = 4'h2;
    localparam logic [3:0] OP_OR     = 4'h3;
    localparam logic [3:0] OP_SUB    = 4'h4;
    localparam logic [3:0] OP_NEG    = 4'h5;
    localparam logic [3:0] OP_NOT    = 4'h6;
    localparam logic [3:0] OP_CPY    = 4'h7;
    localparam logic [3:0] OP_LRG    = 4'h8;
    localparam logic [3:0] OP_BLT    = 4'h9;
    localparam logic [3:0] OP_BGT    = 4'hA;
    localparam logic [3:0] OP_BEQ    = 4'hB;
    localparam logic [3:0] OP_BNE    = 4'hC;
    localparam logic [3:0] OP_JMP    = 4'hD;
    localparam logic [3:0] OP_INPUT  = 4'hE;
    localparam logic [3:0] OP_OUTPUT = 4'hF;

    localparam logic [2:0] CMD_TSTR1 = 3'd0;

    localparam logic [1:0] DT_ALU = 2'b00;
    localparam logic [1:0] DT_IMM = 2'b01;
    localparam logic [1:0] DT_IN  = 2'b10;

    // Branch decision from the ALU result seen in the decode cycle.
    // BGT is strictly greater: a non-negative result that is also non-zero.
    function automatic logic branch_taken(input logic [3:0]               op,
                                          input logic signed [DATA_W-1:0] r);
        logic neg;
        logic zero;
        neg  = r[DATA_W-1];
        zero = (r == '0);
        case (op)
            OP_BLT:  branch_taken = neg;
            OP_BGT:  branch_taken = !neg && !zero;
            OP_BEQ:  branch_taken = zero;
            OP_BNE:  branch_taken = !zero;
            default: branch_taken = 1'b0;
        endcase
    endfunction

    state_e           state_q;
    logic             imem_req_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [2:0]       cmd_q;
    logic [1:0]       seldtwr_q;
    logic             selregwr_q;
    logic             wr_q;
    logic             ldpc_q;
    logic             seljmp_q;
    logic             seldesv_q;
    logic             ldout_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_d = cnt_q + CNT_W'(1);

    // Each state assigns the outputs it owns. Registered values therefore show
    // up in the following state: Wr from DEC is seen in NEXT, and LdPC from
    // NEXT is seen in CLR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_CLR;
            imem_req_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cmd_q       <= CMD_TSTR1;
            seldtwr_q   <= DT_ALU;
            selregwr_q  <= 1'b0;
            wr_q        <= 1'b0;
            ldpc_q      <= 1'b0;
            seljmp_q    <= 1'b0;
            seldesv_q   <= 1'b0;
            ldout_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_CLR: begin
                    wr_q       <= 1'b0;
                    ldpc_q     <= 1'b0;
                    seljmp_q   <= 1'b0;
                    seldesv_q  <= 1'b0;
                    ldout_q    <= 1'b0;
                    selregwr_q <= 1'b0;
                    seldtwr_q  <= DT_ALU;
                    cmd_q      <= CMD_TSTR1;
                    imem_req_q <= 1'b1;
                    state_q    <= S_FETCH;
                end

                // Waits for the memory with no timeout.
                S_FETCH: begin
                    if (imem_ack) begin
                        imem_req_q <= 1'b0;
                        state_q    <= S_DEC;
                    end
                end

                S_DEC: begin
                    state_q <= S_NEXT;
                    case (OP)
                        OP_NOP: begin
                        end
                        OP_ADD, OP_AND, OP_OR, OP_SUB, OP_NEG, OP_NOT: begin
                            // Opcodes 1..6 map one-to-one onto the ALU commands.
                            cmd_q      <= OP[2:0];
                            seldtwr_q  <= DT_ALU;
                            selregwr_q <= 1'b0;
                            wr_q       <= 1'b1;
                        end
                        OP_CPY: begin
                            cmd_q      <= CMD_TSTR1;
                            seldtwr_q  <= DT_ALU;
                            selregwr_q <= 1'b0;
                            wr_q       <= 1'b1;
                        end
                        OP_LRG: begin
                            selregwr_q <= 1'b1;
                            seldtwr_q  <= DT_IMM;
                            wr_q       <= 1'b1;
                        end
                        OP_BLT, OP_BGT, OP_BEQ, OP_BNE: begin
                            cmd_q     <= CMD_TSTR1;
                            seldesv_q <= branch_taken(OP, ResultULA);
                        end
                        OP_JMP: begin
                            seljmp_q <= 1'b1;
                        end
                        OP_INPUT: begin
                            seldtwr_q  <= DT_IN;
                            selregwr_q <= 1'b0;
                            in_ready_q <= 1'b1;
                            // If a word is already available, take it now and
                            // skip the wait state.
                            if (in_valid) begin
                                wr_q <= 1'b1;
                            end else begin
                                state_q <= S_WIN;
                            end
                        end
                        OP_OUTPUT: begin
                            cmd_q       <= CMD_TSTR1;
                            ldout_q     <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= S_WOUT;
                        end
                        default: begin
                        end
                    endcase
                end

                // SelJMP/SelDesv are left as set in DEC so they stay valid
                // alongside LdPC.
                S_NEXT: begin
                    ldpc_q     <= 1'b1;
                    wr_q       <= 1'b0;
                    in_ready_q <= 1'b0;
                    cnt_q      <= cnt_d;
                    state_q    <= S_CLR;
                end

                S_WIN: begin
                    if (in_valid) begin
                        wr_q       <= 1'b1;
                        in_ready_q <= 1'b0;
                        state_q    <= S_NEXT;
                    end
                end

                S_WOUT: begin
                    ldout_q <= 1'b0;
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_NEXT;
                    end
                end

                // Codes 6 and 7 are never entered in normal operation. If
                // reached, restart the instruction.
                default: begin
                    state_q <= S_CLR;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign CmdULA    = cmd_q;
    assign selDtWr   = seldtwr_q;
    assign SelRegWr  = selregwr_q;
    assign Wr        = wr_q;
    assign LdPC      = ldpc_q;
    assign SelJMP    = seljmp_q;
    assign SelDesv   = seldesv_q;
    assign LdOUTPUT  = ldout_q;
    assign estado    = state_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_nano_ctrl_hs.sv
// -----------------------------------------------------------------------------
// tb_nano_ctrl_hs
// Directed bench for nano_ctrl_hs. A table of single-cycle-decode instructions
// runs with expected strobes for each. Hand-written sequences cover FETCH
// wait, INPUT/OUTPUT handshakes, reset mid-handshake and counter wrap. A
// second instance with CNT_W=2 shares the stimulus for the wrap checks.
// -----------------------------------------------------------------------------
module tb_nano_ctrl_hs;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] OP;
    logic [7:0] ResultULA;
    logic       imem_ack, in_valid, out_ready;

    logic        imem_req, in_ready, out_valid, SelRegWr, Wr, LdPC, SelJMP, SelDesv, LdOUTPUT;
    logic [2:0]  CmdULA, estado;
    logic [1:0]  selDtWr;
    logic [15:0] instr_cnt;

    logic        imem_req_b, in_ready_b, out_valid_b, SelRegWr_b, Wr_b, LdPC_b, SelJMP_b, SelDesv_b, LdOUTPUT_b;
    logic [2:0]  CmdULA_b, estado_b;
    logic [1:0]  selDtWr_b;
    logic [1:0]  instr_cnt_b;

    always #5 clk = ~clk;

    nano_ctrl_hs #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .OP(OP), .ResultULA(ResultULA), .imem_ack(imem_ack),
        .in_valid(in_valid), .out_ready(out_ready), .imem_req(imem_req),
        .in_ready(in_ready), .out_valid(out_valid), .CmdULA(CmdULA), .selDtWr(selDtWr),
        .SelRegWr(SelRegWr), .Wr(Wr), .LdPC(LdPC), .SelJMP(SelJMP), .SelDesv(SelDesv),
        .LdOUTPUT(LdOUTPUT), .estado(estado), .instr_cnt(instr_cnt)
    );

    nano_ctrl_hs #(.DATA_W(8), .CNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .OP(OP), .ResultULA(ResultULA), .imem_ack(imem_ack),
        .in_valid(in_valid), .out_ready(out_ready), .imem_req(imem_req_b),
        .in_ready(in_ready_b), .out_valid(out_valid_b), .CmdULA(CmdULA_b), .selDtWr(selDtWr_b),
        .SelRegWr(SelRegWr_b), .Wr(Wr_b), .LdPC(LdPC_b), .SelJMP(SelJMP_b), .SelDesv(SelDesv_b),
        .LdOUTPUT(LdOUTPUT_b), .estado(estado_b), .instr_cnt(instr_cnt_b)
    );

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] res;
        logic [2:0] cmd;
        logic [1:0] sdt;
        logic       srw;
        logic       wr;
        logic       jmp;
        logic       desv;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts and ends with the DUT in CLR.
    task automatic run_vec(input vec_t v, input string tag);
        OP = v.op; ResultULA = v.res; imem_ack = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        chk({tag, "_clr_est"}, 32'(estado), 32'd0);
        tick();
        chk({tag, "_fetch_est"}, 32'(estado), 32'd1);
        chk({tag, "_fetch_req"}, 32'(imem_req), 32'd1);
        chk({tag, "_fetch_desv"}, 32'(SelDesv), 32'd0);
        chk({tag, "_fetch_jmp"}, 32'(SelJMP), 32'd0);
        chk({tag, "_fetch_ldpc"}, 32'(LdPC), 32'd0);
        tick();
        chk({tag, "_dec_est"}, 32'(estado), 32'd2);
        chk({tag, "_dec_req"}, 32'(imem_req), 32'd0);
        tick();
        chk({tag, "_next_est"}, 32'(estado), 32'd3);
        chk({tag, "_cmd"}, 32'(CmdULA), 32'(v.cmd));
        chk({tag, "_sdt"}, 32'(selDtWr), 32'(v.sdt));
        chk({tag, "_srw"}, 32'(SelRegWr), 32'(v.srw));
        chk({tag, "_wr"}, 32'(Wr), 32'(v.wr));
        chk({tag, "_jmp"}, 32'(SelJMP), 32'(v.jmp));
        chk({tag, "_desv"}, 32'(SelDesv), 32'(v.desv));
        chk({tag, "_next_ldpc"}, 32'(LdPC), 32'd0);
        exp_cnt++;
        tick();
        chk({tag, "_end_est"}, 32'(estado), 32'd0);
        chk({tag, "_end_ldpc"}, 32'(LdPC), 32'd1);
        chk({tag, "_end_wr"}, 32'(Wr), 32'd0);
        chk({tag, "_end_desv_held"}, 32'(SelDesv), 32'(v.desv));
        chk({tag, "_end_jmp_held"}, 32'(SelJMP), 32'(v.jmp));
        chk({tag, "_cnt"}, 32'(instr_cnt), 32'(exp_cnt));
        chk({tag, "_cnt_w2"}, 32'(instr_cnt_b), 32'(exp_cnt % 4));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc, wr_n, ld_n, ov_n;
        OP = 4'h0; ResultULA = 8'h00; imem_ack = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        //          op     res    cmd   sdt    srw   wr    jmp   desv
        vecs[0]  = '{4'h0, 8'h00, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0}; // NOP
        vecs[1]  = '{4'h1, 8'h00, 3'd1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0}; // ADD
        vecs[2]  = '{4'h2, 8'h00, 3'd2, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0}; // AND
        vecs[3]  = '{4'h3, 8'h00, 3'd3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0}; // OR
        vecs[4]  = '{4'h4, 8'h00, 3'd4, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0}; // SUB
        vecs[5]  = '{4'h5, 8'h00, 3'd5, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0}; // NEG
        vecs[6]  = '{4'h6, 8'h00, 3'd6, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0}; // NOT
        vecs[7]  = '{4'h7, 8'h00, 3'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0}; // CPY
        vecs[8]  = '{4'h8, 8'h00, 3'd0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0}; // LRG
        vecs[9]  = '{4'h9, 8'h80, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1}; // BLT neg
        vecs[10] = '{4'hA, 8'h80, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0}; // BGT neg
        vecs[11] = '{4'hA, 8'h00, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0}; // BGT zero
        vecs[12] = '{4'hB, 8'h00, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1}; // BEQ zero
        vecs[13] = '{4'hC, 8'h00, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0}; // BNE zero
        vecs[14] = '{4'hA, 8'h05, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1}; // BGT pos
        vecs[15] = '{4'h9, 8'h05, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0}; // BLT pos
        vecs[16] = '{4'hB, 8'h05, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0}; // BEQ pos
        vecs[17] = '{4'hC, 8'h80, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1}; // BNE neg
        vecs[18] = '{4'hD, 8'h00, 3'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0}; // JMP
        vecs[19] = '{4'hB, 8'h7F, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0}; // BEQ max pos

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_est", 32'(estado), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_inr", 32'(in_ready), 32'd0);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_wr", 32'(Wr), 32'd0);
        chk("rst_ldpc", 32'(LdPC), 32'd0);
        chk("rst_cnt", 32'(instr_cnt), 32'd0);
        rst = 1'b1;

        // First ADD after reset: estado 0,1,2,3,0
        OP = 4'h1; imem_ack = 1'b1;
        chk("add_est0", 32'(estado), 32'd0);
        tick(); chk("add_est1", 32'(estado), 32'd1); chk("add_req", 32'(imem_req), 32'd1);
        tick(); chk("add_est2", 32'(estado), 32'd2);
        tick(); chk("add_est3", 32'(estado), 32'd3); chk("add_cmd", 32'(CmdULA), 32'd1);
        chk("add_wr", 32'(Wr), 32'd1); chk("add_ldpc3", 32'(LdPC), 32'd0);
        exp_cnt++;
        tick(); chk("add_est0b", 32'(estado), 32'd0); chk("add_ldpc", 32'(LdPC), 32'd1);
        chk("add_cnt", 32'(instr_cnt), 32'd1);

        // FETCH wait: imem_ack low for 3 FETCH cycles -> period 7
        OP = 4'h1; imem_ack = 1'b0;
        cyc = 0;
        for (int c = 0; c < 3; c++) begin
            tick(); cyc++;
            chk("fw_est", 32'(estado), 32'd1);
            chk("fw_req", 32'(imem_req), 32'd1);
        end
        tick(); cyc++;
        chk("fw_est4", 32'(estado), 32'd1);
        imem_ack = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick(); cyc++;
            if (estado == 3'd0) break;
        end
        exp_cnt++;
        chk("fw_period", 32'(cyc), 32'd7);
        chk("fw_cnt", 32'(instr_cnt), 32'(exp_cnt));

        // Table of single-cycle-decode instructions
        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // INPUT, in_valid low for 2 WIN cycles: estado 2,4,4,4,3
        OP = 4'hE; in_valid = 1'b0; wr_n = 0;
        tick(); chk("inw_fetch", 32'(estado), 32'd1);
        tick(); chk("inw_dec", 32'(estado), 32'd2);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("inw_est", 32'(estado), 32'd4);
            chk("inw_rdy", 32'(in_ready), 32'd1);
            if (Wr) wr_n++;
            if (c == 2) in_valid = 1'b1;
        end
        tick();
        chk("inw_next", 32'(estado), 32'd3);
        chk("inw_wr", 32'(Wr), 32'd1);
        chk("inw_sdt", 32'(selDtWr), 32'd2);
        chk("inw_rdy0", 32'(in_ready), 32'd0);
        if (Wr && selDtWr == 2'b10) wr_n++;
        in_valid = 1'b0;
        exp_cnt++;
        tick();
        if (Wr) wr_n++;
        chk("inw_wr_once", 32'(wr_n), 32'd1);
        chk("inw_end", 32'(estado), 32'd0);
        chk("inw_cnt", 32'(instr_cnt), 32'(exp_cnt));

        // INPUT with in_valid already high: 4-cycle period
        OP = 4'hE; in_valid = 1'b1;
        tick(); tick();
        chk("inf_dec", 32'(estado), 32'd2);
        tick();
        chk("inf_next", 32'(estado), 32'd3);
        chk("inf_wr", 32'(Wr), 32'd1);
        chk("inf_rdy", 32'(in_ready), 32'd1);
        chk("inf_sdt", 32'(selDtWr), 32'd2);
        in_valid = 1'b0;
        exp_cnt++;
        tick();
        chk("inf_end", 32'(estado), 32'd0);
        chk("inf_rdy0", 32'(in_ready), 32'd0);
        chk("inf_wr0", 32'(Wr), 32'd0);

        // OUTPUT, out_ready low for 3 WOUT cycles
        OP = 4'hF; out_ready = 1'b0; ld_n = 0; ov_n = 0;
        tick(); tick();
        chk("out_dec", 32'(estado), 32'd2);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("out_est", 32'(estado), 32'd5);
            if (c == 0) chk("out_ld_first", 32'(LdOUTPUT), 32'd1);
            if (LdOUTPUT) ld_n++;
            if (out_valid) ov_n++;
            if (c == 3) out_ready = 1'b1;
        end
        tick();
        chk("out_next", 32'(estado), 32'd3);
        chk("out_ov0", 32'(out_valid), 32'd0);
        chk("out_ld0", 32'(LdOUTPUT), 32'd0);
        out_ready = 1'b0;
        exp_cnt++;
        tick();
        chk("out_ld_n", 32'(ld_n), 32'd1);
        chk("out_ov_n", 32'(ov_n), 32'd4);
        chk("out_end", 32'(estado), 32'd0);
        chk("out_cnt", 32'(instr_cnt), 32'(exp_cnt));

        // Reset asserted while waiting in WOUT
        OP = 4'hF; out_ready = 1'b0;
        tick(); tick(); tick();
        chk("rw_wout", 32'(estado), 32'd5);
        chk("rw_ov1", 32'(out_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("rw_ov", 32'(out_valid), 32'd0);
        chk("rw_est", 32'(estado), 32'd0);
        chk("rw_cnt", 32'(instr_cnt), 32'd0);
        chk("rw_cnt_w2", 32'(instr_cnt_b), 32'd0);
        chk("rw_ld", 32'(LdOUTPUT), 32'd0);
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Five instructions after reset: CNT_W=2 wraps to 1
        for (int i = 0; i < 5; i++) run_vec(vecs[1], $sformatf("wrap%0d", i));
        chk("wrap_w2", 32'(instr_cnt_b), 32'd1);
        chk("wrap_w16", 32'(instr_cnt), 32'd5);
        chk("wrap_ov", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
